// File: rtl/decoder.sv
// Bipolar line decoder: recovers one data bit per slot from P/N pulses, strips
// four-zero substitutions, flags code errors and loss of signal. Optional error counter: DECODER_ERR_CNT_EN.
module decoder #(
    parameter int LOS_LIMIT = 16,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             P,
    input  logic             N,
    output logic             data,
    output logic             code_err,
    output logic             los,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [7:0] LOS_MAX = 8'(LOS_LIMIT);

    logic       lastpol, lastpol_n;
    logic [1:0] zrun, zrun_n;
    logic [7:0] loscnt, loscnt_n;
    logic       data_n, err_n, los_n;

    // Slot decode; an illegal P=N=1 slot advances the zero run like an empty one
    always_comb begin
        data_n    = 1'b0;
        err_n     = 1'b0;
        los_n     = los;
        lastpol_n = lastpol;
        zrun_n    = zrun;
        loscnt_n  = loscnt;
        if (P ^ N) begin
            if (P != lastpol) begin
                data_n    = 1'b1;
                lastpol_n = P;
            end else begin
                err_n = (zrun != 2'd3);
            end
            zrun_n   = 2'd0;
            loscnt_n = 8'd0;
            los_n    = 1'b0;
        end else begin
            if (P & N)
                err_n = 1'b1;
            if (zrun == 2'd3)
                err_n = 1'b1;
            else
                zrun_n = zrun + 2'd1;
            if (loscnt < LOS_MAX)
                loscnt_n = loscnt + 8'd1;
            if (loscnt_n == LOS_MAX)
                los_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data     <= 1'b0;
            code_err <= 1'b0;
            los      <= 1'b0;
            lastpol  <= 1'b1;
            zrun     <= 2'd0;
            loscnt   <= 8'd0;
        end else begin
            data     <= data_n;
            code_err <= err_n;
            los      <= los_n;
            lastpol  <= lastpol_n;
            zrun     <= zrun_n;
            loscnt   <= loscnt_n;
        end
    end

`ifdef DECODER_ERR_CNT_EN
    // Counts on the same edge that raises code_err, so both outputs move together
    always_ff @(posedge clk) begin
        if (reset)
            err_cnt <= '0;
        else if (err_n && (err_cnt != {ERR_W{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for decoder (LOS_LIMIT=16, ERR_W=2); err_cnt
// expectations follow DECODER_ERR_CNT_EN.
module tb_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       P;
    logic       N;
    logic       data;
    logic       code_err;
    logic       los;
    logic [1:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int errModel = 0;

    decoder #(.LOS_LIMIT(16), .ERR_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .P        (P),
        .N        (N),
        .data     (data),
        .code_err (code_err),
        .los      (los),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic p, input logic n);
        P = p;
        N = n;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic expData,
                               input logic expErr, input logic expLos);
        logic [1:0] expCnt;
        if (expErr && errModel < 3)
            errModel++;
`ifdef DECODER_ERR_CNT_EN
        expCnt = 2'(errModel);
`else
        expCnt = 2'd0;
`endif
        checks++;
        assert (data === expData) else begin
            failures++;
            $error("[TB] FAIL %s data: got %b expected %b", tag, data, expData);
        end
        checks++;
        assert (code_err === expErr) else begin
            failures++;
            $error("[TB] FAIL %s code_err: got %b expected %b", tag, code_err, expErr);
        end
        checks++;
        assert (los === expLos) else begin
            failures++;
            $error("[TB] FAIL %s los: got %b expected %b", tag, los, expLos);
        end
        checks++;
        assert (err_cnt === expCnt) else begin
            failures++;
            $error("[TB] FAIL %s err_cnt: got %0d expected %0d", tag, err_cnt, expCnt);
        end
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0);
        reset = 1'b0;
        errModel = 0;
        checkOutput(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        P = 1'b1;
        N = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset", 1'b0, 1'b0, 1'b0);

        // Clean stream N,P,0,0,0,P,N -> 1,1,0,0,0,0,1
        applyStimulus(1'b0, 1'b1); checkOutput("clean0", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0); checkOutput("clean1", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0); checkOutput("clean2", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0); checkOutput("clean3", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0); checkOutput("clean4", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0); checkOutput("clean5", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1); checkOutput("clean6", 1'b1, 1'b0, 1'b0);

        // First pulse P after reset is a violation, then N is a mark
        doReset("reset2");
        applyStimulus(1'b1, 1'b0); checkOutput("firstP", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1); checkOutput("afterP", 1'b1, 1'b0, 1'b0);

        // Five empties after mark N: errors on the 4th and 5th
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("miss%0d", i), 1'b0, i >= 4, 1'b0);
        end
        applyStimulus(1'b1, 1'b0); checkOutput("missMark", 1'b1, 1'b0, 1'b0);

        // N,P, illegal, N -> 1,1,0,1
        applyStimulus(1'b0, 1'b1); checkOutput("ill0", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0); checkOutput("ill1", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1); checkOutput("ill2", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1); checkOutput("ill3", 1'b1, 1'b0, 1'b0);

        // Loss of signal after 16 empties, held, cleared by a mark
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("los%0d", i), 1'b0, i >= 4, i >= 16);
        end
        applyStimulus(1'b1, 1'b0); checkOutput("losMark", 1'b1, 1'b0, 1'b0);

        // Five illegal slots: back-to-back errors, counter saturates
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("errInj%0d", i), 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1); checkOutput("errMark", 1'b1, 1'b0, 1'b0);

        // Raise los again, then reset mid-stream
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("los2_%0d", i), 1'b0, i >= 4, i >= 16);
        end
        doReset("midReset");
        applyStimulus(1'b0, 1'b1); checkOutput("postReset", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0); checkOutput("postReset0", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
